simon_seq_engine: RTL and testbench

//   Parametrised Simon game core: grows a random sequence, plays it back, checks player entries.

---
 rtl/simon_pkg.sv | 29 ++
 rtl/simon_seq_mem.sv | 26 ++
 rtl/simon_seq_engine.sv | 206 ++++++++++++++++++++
 tb/tb_simon_seq_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and width helpers for the Simon sequence engine.
package simon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAdd,
    StShowOn,
    StShowOff,
    StWaitIn,
    StEcho,
    StWin,
    StLose
  } state_t;

  // Symbol width; at least one bit even for degenerate counts.
  function automatic int sym_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold 0..d inclusive.
  function automatic int level_width(int d);
    return $clog2(d + 1);
  endfunction

  function automatic int addr_width(int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Sequence storage: DEPTH x BW flops, one synchronous write port, one combinational read port.
module simon_seq_mem #(
  parameter int DEPTH = 16,
  parameter int BW    = 2,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  // Contents are never read above level-1, so no reset is needed.
  logic [BW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/simon_seq_engine.sv
// Simon game core: grows a random sequence, plays it back first-to-last, and checks player
// entries forward or reversed with a per-entry timeout.
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int NUM_BUTTONS   = 4,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 8,
  localparam int BW = sym_width(NUM_BUTTONS),
  localparam int LW = level_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          reverse,
  input  logic [BW-1:0] rand_sym,
  input  logic [BW-1:0] in_sym,
  input  logic          in_valid,
  input  logic          timer_pulse,
  output logic          timer_go,
  output logic [BW-1:0] out_sym,
  output logic          out_ena,
  output logic          win,
  output logic          lose,
  output logic          hs,
  output logic [LW-1:0] level
);

  localparam int AW = addr_width(DEPTH);
  localparam int TW = level_width(TIMEOUT_TICKS);
  localparam logic [LW-1:0] LvOne  = LW'(1);
  localparam logic [LW-1:0] LvMax  = LW'(DEPTH);
  localparam logic [TW-1:0] TOne   = TW'(1);
  localparam logic [TW-1:0] TLimit = TW'(TIMEOUT_TICKS);
  localparam logic [BW:0]   NumSym = (BW + 1)'(NUM_BUTTONS);

  state_t        state_q;
  logic [LW-1:0] level_q, idx_q, hs_reg_q;
  logic [TW-1:0] tcnt_q;
  logic          start_q, rev_q;
  logic          timer_go_q, out_ena_q, win_q, lose_q, hs_q;
  logic [BW-1:0] out_q;

  logic          start_rise;
  logic [BW:0]   rand_ext;
  logic [BW-1:0] rand_mod, rd_data;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] last_idx;
  logic          last_entry;

  assign start_rise = start & ~start_q;
  assign rand_ext   = {1'b0, rand_sym} % NumSym;
  assign rand_mod   = rand_ext[BW-1:0];
  // Also the LOSE score: rounds fully completed before the failing one.
  assign last_idx   = level_q - LvOne;
  assign last_entry = rev_q ? (idx_q == '0) : (idx_q == last_idx);

  // Read address looks ahead so the registered OUT is ready on entry to SHOW_ON.
  always_comb begin
    rd_addr = AW'(idx_q);
    if (state_q == StAdd) begin
      rd_addr = '0;
    end else if (state_q == StShowOff) begin
      rd_addr = AW'(idx_q + LvOne);
    end
  end

  simon_seq_mem #(
    .DEPTH(DEPTH),
    .BW   (BW),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (state_q == StAdd),
    .waddr(AW'(level_q)),
    .wdata(rand_mod),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      level_q    <= '0;
      idx_q      <= '0;
      tcnt_q     <= '0;
      hs_reg_q   <= '0;
      start_q    <= 1'b0;
      rev_q      <= 1'b0;
      timer_go_q <= 1'b0;
      out_q      <= '0;
      out_ena_q  <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      hs_q       <= 1'b0;
    end else begin
      start_q    <= start;
      timer_go_q <= 1'b0;
      unique case (state_q)
        StIdle, StWin, StLose: begin
          if (start_rise) begin
            level_q <= '0;
            idx_q   <= '0;
            hs_q    <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            rev_q   <= reverse;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          level_q    <= level_q + LvOne;
          idx_q      <= '0;
          // Slot 0 is being written this cycle on the first round.
          out_q      <= (level_q == '0) ? rand_mod : rd_data;
          out_ena_q  <= 1'b1;
          timer_go_q <= 1'b1;
          state_q    <= StShowOn;
        end
        StShowOn: begin
          if (timer_pulse) begin
            out_ena_q  <= 1'b0;
            timer_go_q <= 1'b1;
            state_q    <= StShowOff;
          end
        end
        StShowOff: begin
          if (timer_pulse) begin
            timer_go_q <= 1'b1;
            if (idx_q == last_idx) begin
              idx_q   <= rev_q ? last_idx : '0;
              tcnt_q  <= '0;
              state_q <= StWaitIn;
            end else begin
              idx_q     <= idx_q + LvOne;
              out_q     <= rd_data;
              out_ena_q <= 1'b1;
              state_q   <= StShowOn;
            end
          end
        end
        StWaitIn: begin
          if (in_valid) begin
            if (in_sym == rd_data) begin
              out_q      <= in_sym;
              out_ena_q  <= 1'b1;
              timer_go_q <= 1'b1;
              state_q    <= StEcho;
            end else begin
              lose_q  <= 1'b1;
              state_q <= StLose;
              if (last_idx > hs_reg_q) begin
                hs_reg_q <= last_idx;
                hs_q     <= 1'b1;
              end
            end
          end else if (timer_pulse) begin
            if (tcnt_q + TOne == TLimit) begin
              lose_q  <= 1'b1;
              state_q <= StLose;
              if (last_idx > hs_reg_q) begin
                hs_reg_q <= last_idx;
                hs_q     <= 1'b1;
              end
            end else begin
              tcnt_q     <= tcnt_q + TOne;
              timer_go_q <= 1'b1;
            end
          end
        end
        StEcho: begin
          if (timer_pulse) begin
            out_ena_q <= 1'b0;
            if (last_entry) begin
              if (level_q == LvMax) begin
                win_q   <= 1'b1;
                state_q <= StWin;
                if (LvMax > hs_reg_q) begin
                  hs_reg_q <= LvMax;
                  hs_q     <= 1'b1;
                end
              end else begin
                state_q <= StAdd;
              end
            end else begin
              idx_q      <= rev_q ? idx_q - LvOne : idx_q + LvOne;
              tcnt_q     <= '0;
              timer_go_q <= 1'b1;
              state_q    <= StWaitIn;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign timer_go = timer_go_q;
  assign out_sym  = out_q;
  assign out_ena  = out_ena_q;
  assign win      = win_q;
  assign lose     = lose_q;
  assign hs       = hs_q;
  assign level    = level_q;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Scoreboard bench for simon_seq_engine: 4 buttons, depth 4, timeout 3, timer pulses 4 after GO.
module tb_simon_seq_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       reverse = 1'b0;
  logic       in_valid = 1'b0;
  logic       timer_pulse = 1'b0;
  logic [1:0] rand_sym = 2'd0;
  logic [1:0] in_sym = 2'd0;
  logic       timer_go, out_ena, win, lose, hs;
  logic [1:0] out_sym;
  logic [2:0] level;

  typedef struct packed {
    logic       win;
    logic       lose;
    logic       hs;
    logic [2:0] level;
  } end_t;

  logic [1:0] exp_sym_q[$];
  end_t       exp_end_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         seq[4] = '{2, 1, 3, 0};
  int         tmr_cnt = 0;

  simon_seq_engine #(
    .NUM_BUTTONS  (4),
    .DEPTH        (4),
    .TIMEOUT_TICKS(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .reverse    (reverse),
    .rand_sym   (rand_sym),
    .in_sym     (in_sym),
    .in_valid   (in_valid),
    .timer_pulse(timer_pulse),
    .timer_go   (timer_go),
    .out_sym    (out_sym),
    .out_ena    (out_ena),
    .win        (win),
    .lose       (lose),
    .hs         (hs),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Timer model: GO seen at a negedge raises a pulse sampled by the 4th following posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (timer_go) tmr_cnt = 4;
      else if (tmr_cnt > 0) tmr_cnt--;
      timer_pulse = (tmr_cnt == 1);
    end
  end

  // Monitor: pops an expectation on every display rising edge and every WIN/LOSE entry.
  initial begin
    logic pe, pw;
    logic [1:0] es;
    end_t ee;
    pe = 1'b0;
    pw = 1'b0;
    forever begin
      @(negedge clk);
      if (out_ena && !pe) begin
        if (exp_sym_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_display: got out_sym=%0d, expected no display", out_sym);
        end else begin
          es = exp_sym_q.pop_front();
          check("out_sym", int'(out_sym), int'(es));
        end
      end
      if ((win || lose) && !pw) begin
        if (exp_end_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_end: got win=%0d lose=%0d, expected none", win, lose);
        end else begin
          ee = exp_end_q.pop_front();
          check("end_win", int'(win), int'(ee.win));
          check("end_lose", int'(lose), int'(ee.lose));
          check("end_hs", int'(hs), int'(ee.hs));
          check("end_level", int'(level), int'(ee.level));
        end
      end
      pe = out_ena;
      pw = win || lose;
    end
  end

  task automatic wait_go(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      seen = timer_go;
    end
    check(name, int'(seen), 1);
  endtask

  task automatic start_game(input bit rev);
    @(negedge clk);
    rand_sym = 2'(seq[0]);
    reverse  = rev;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic watch_playback(input int len);
    for (int i = 0; i < len; i++) exp_sym_q.push_back(2'(seq[i]));
    for (int g = 0; g < 2 * len + 1; g++) begin
      wait_go("playback_go");
      if (g == 0 && len < 4) rand_sym = 2'(seq[len]);
    end
  endtask

  task automatic press(input logic [1:0] s, input bit ok, input bit sync);
    if (ok) exp_sym_q.push_back(s);
    if (sync) begin
      bit seen = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
        @(negedge clk);
        #1;
        seen = timer_pulse;
      end
      check("sync_pulse", int'(seen), 1);
    end
    in_sym   = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic play_round(input int len, input bit rev, input int wpos, input logic [1:0] wsym);
    int e;
    watch_playback(len);
    for (int j = 0; j < len; j++) begin
      e = rev ? seq[len-1-j] : seq[j];
      if (j == wpos) begin
        press(wsym, 1'b0, 1'b0);
        return;
      end
      press(2'(e), 1'b1, 1'b0);
      if (j < len - 1) wait_go("reentry_go");
    end
  endtask

  task automatic expect_end(input bit w, input bit l, input bit h, input int lv);
    end_t r;
    r.win   = w;
    r.lose  = l;
    r.hs    = h;
    r.level = 3'(lv);
    exp_end_q.push_back(r);
  endtask

  task automatic wait_end(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 128 && !seen; k++) begin
      @(negedge clk);
      seen = win || lose;
    end
    check(name, int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_timer_go", int'(timer_go), 0);
    check("rst_out_ena", int'(out_ena), 0);
    check("rst_out_sym", int'(out_sym), 0);
    check("rst_win", int'(win), 0);
    check("rst_lose", int'(lose), 0);
    check("rst_hs", int'(hs), 0);
    check("rst_level", int'(level), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset while a symbol is on display.
    start_game(1'b0);
    exp_sym_q.push_back(2'(seq[0]));
    wait_go("t1_show_go");
    check("t1_level_before", int'(level), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_out_ena", int'(out_ena), 0);
    check("t1_async_out_sym", int'(out_sym), 0);
    check("t1_async_level", int'(level), 0);
    check("t1_async_timer_go", int'(timer_go), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_idle_timer_go", int'(timer_go), 0);
      check("t1_idle_level", int'(level), 0);
    end

    // Forward game lost in round 2; first score sets HS.
    start_game(1'b0);
    play_round(1, 1'b0, -1, 2'd0);
    expect_end(1'b0, 1'b1, 1'b1, 2);
    play_round(2, 1'b0, 1, 2'd3);
    wait_end("t3_end");
    repeat (10) @(negedge clk);

    // Forward game won.
    start_game(1'b0);
    for (int r = 1; r <= 3; r++) play_round(r, 1'b0, -1, 2'd0);
    expect_end(1'b1, 1'b0, 1'b1, 4);
    play_round(4, 1'b0, -1, 2'd0);
    wait_end("t2_end");
    repeat (10) @(negedge clk);

    // Reverse entry through round 3, then wrong first entry in round 4.
    start_game(1'b1);
    for (int r = 1; r <= 3; r++) play_round(r, 1'b1, -1, 2'd0);
    expect_end(1'b0, 1'b1, 1'b0, 4);
    play_round(4, 1'b1, 0, 2'd2);
    wait_end("t4a_end");
    repeat (10) @(negedge clk);

    // Reverse, round 3 entered forward-first (2 instead of 3).
    start_game(1'b1);
    for (int r = 1; r <= 2; r++) play_round(r, 1'b1, -1, 2'd0);
    expect_end(1'b0, 1'b1, 1'b0, 3);
    play_round(3, 1'b1, 0, 2'd2);
    wait_end("t4b_end");
    repeat (10) @(negedge clk);

    // Timeout: GO after 1st and 2nd idle ticks, LOSE on the 3rd.
    start_game(1'b0);
    watch_playback(1);
    wait_go("t5_tick1_go");
    wait_go("t5_tick2_go");
    expect_end(1'b0, 1'b1, 1'b0, 1);
    wait_end("t5_end");
    check("t5_no_go_on_lose", int'(timer_go), 0);
    repeat (10) @(negedge clk);

    // Entry coinciding with the would-be timeout tick wins; then score 1 below hs_reg.
    start_game(1'b0);
    watch_playback(1);
    wait_go("t6_tick1_go");
    wait_go("t6_tick2_go");
    press(2'(seq[0]), 1'b1, 1'b1);
    check("t6_no_lose", int'(lose), 0);
    expect_end(1'b0, 1'b1, 1'b0, 2);
    play_round(2, 1'b0, 0, 2'd3);
    wait_end("t6_end");
    repeat (10) @(negedge clk);

    check("sym_queue_drained", exp_sym_q.size(), 0);
    check("end_queue_drained", exp_end_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
